sram_master: RTL and testbench

Initiator-side controller for the single-port synchronous instruction/data SRAM. It accepts single-beat write requests and 1–16 beat incrementing read bursts from the CPU datapath over a valid/ready handshake. It drives the SRAM's chip-select, write-enable, address and write-data pins, and returns read data as a registered response stream. The block compensates for the SRAM's one-cycle registered read latency. It sits between the CPU load/store and fetch logic and the SRAM instance.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_rsp_pipe.sv | 41 ++++
 rtl/sram_master.sv | 125 ++++++++++++
 tb/tb_sram_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM initiator: FSM state encoding and default
// request field widths used by the CPU load/store and fetch logic.
package sram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WIDTH_DEF  = 32;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rsp_pipe.sv
// Two-stage response pipeline: stage 1 tracks issued read beats while the
// SRAM's registered output settles, stage 2 captures the data word.
module sram_rsp_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_i,
  input  logic             issue_last_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic             rsp_valid_o,
  output logic             rsp_last_o,
  output logic [WIDTH-1:0] rsp_data_o
);

  logic             s1_valid_q, s1_last_q;
  logic             rsp_valid_q, rsp_last_q;
  logic [WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      s1_valid_q  <= issue_i;
      s1_last_q   <= issue_last_i;
      rsp_valid_q <= s1_valid_q;
      rsp_last_q  <= s1_last_q;
      // sram_rdata only holds a meaningful word the cycle after an issue
      if (s1_valid_q) rsp_data_q <= rdata_i;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/sram_master.sv
// Initiator for the single-port synchronous SRAM: single-beat writes and
// 1..2^LEN_W beat incrementing read bursts with a registered response stream.
module sram_master
  import sram_pkg::*;
#(
  parameter int ADDR   = ADDR_W_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LENGTH = 256,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             sram_cs,
  output logic             sram_we,
  output logic [ADDR-1:0]  sram_addr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
);

  localparam logic [ADDR:0] LEN_EXT = (ADDR+1)'(LENGTH);

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic             cs_q, we_q, ready_q, busy_q;
  logic [ADDR-1:0]  addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic [ADDR-1:0]  start_addr_d, next_addr_d;
  logic [ADDR:0]    next_wide;
  logic             issue, issue_last;

  // Address arithmetic carries one spare bit so the wrap test sees LENGTH.
  always_comb begin
    start_addr_d = ADDR'({1'b0, req_addr} % LEN_EXT);
    next_wide    = {1'b0, addr_q} + (ADDR+1)'(1);
    next_addr_d  = (next_wide >= LEN_EXT) ? '0 : next_wide[ADDR-1:0];
  end

  // NOTE: every register in a clocked block is assigned with <=, so all reads
  // inside it see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid && ready_q) begin
          cs_q    <= 1'b1;
          addr_q  <= start_addr_d;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          if (req_we) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            wdata_q <= req_wdata;
          end else begin
            state_q     <= READ;
            we_q        <= 1'b0;
            remaining_q <= req_len;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        READ: begin
          if (remaining_q == '0) begin
            state_q <= DRAIN;
            cs_q    <= 1'b0;
          end else begin
            remaining_q <= remaining_q - LEN_W'(1);
            addr_q      <= next_addr_d;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue      = (state_q == READ);
  assign issue_last = issue && (remaining_q == '0);

  sram_rsp_pipe #(.WIDTH(WIDTH)) u_rsp_pipe (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue),
    .issue_last_i (issue_last),
    .rdata_i      (sram_rdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_last_o   (rsp_last),
    .rsp_data_o   (rsp_data)
  );

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign sram_cs    = cs_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master wired to a behavioural registered-read SRAM;
// read beats are predicted into a scoreboard at accept and compared on output.
module tb_sram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_last, busy;
  logic [31:0] rsp_data;
  logic        sram_cs, sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NOTE: the SRAM array has no reset, like the real macro; only written words are read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] shadow [256];
  logic [7:0]  addr_log[$];
  int          wr_cycles = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: log SRAM activity and score every response beat.
  always @(negedge clk) begin
    if (sram_cs && !sram_we) addr_log.push_back(sram_addr);
    if (sram_cs && sram_we) wr_cycles++;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        got = sb.pop_front();
        check("rsp_data", rsp_data, got.data);
        check("rsp_last", 32'(rsp_last), 32'(got.last));
        check("rsp_cycle", 32'(cyc), 32'(got.cyc));
      end
    end
  end

  // Called and returns #1 after a rising edge; acc is the cycle count just after the accept edge.
  task automatic send(input logic we, input logic [7:0] addr, input logic [3:0] len,
                      input logic [31:0] wd, input bit hold, output int acc);
    exp_t e;
    req_we = we; req_addr = addr; req_len = len; req_wdata = wd; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hold) req_valid = 1'b0;
    if (acc < 0) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
    end else if (we) begin
      shadow[addr] = wd;
    end else begin
      for (int k = 0; k <= int'(len); k++) begin
        e.data = shadow[8'(int'(addr) + k)];
        e.last = (k == int'(len));
        e.cyc  = acc + 2 + k;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    int a;
    send(1'b1, addr, 4'd0, data, 1'b0, a);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int          a1, a2, w0;
  logic [7:0]  wrap_exp [4];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_flags", 32'({busy, sram_cs, sram_we, rsp_valid, rsp_last}), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then single read
    w0 = wr_cycles;
    send(1'b1, 8'h10, 4'd0, 32'hDEADBEEF, 1'b0, a1);
    check("wr_pins", 32'({sram_cs, sram_we}), 32'd3);
    check("wr_addr", 32'(sram_addr), 32'h10);
    check("wr_wdata", sram_wdata, 32'hDEADBEEF);
    check("wr_busy_ready", 32'({busy, req_ready}), 32'b10);
    @(posedge clk); #1;
    check("wr_ready_c2", 32'({busy, req_ready}), 32'b01);
    send(1'b0, 8'h10, 4'd0, 32'd0, 1'b0, a1);
    wait_drain();
    check("wr_one_cycle", 32'(wr_cycles - w0), 32'd1);

    // Burst read of 1,2,3,4
    for (int i = 0; i < 4; i++) wr(8'(8'h20 + i), 32'(i + 1));
    send(1'b0, 8'h20, 4'd3, 32'd0, 1'b0, a1);
    repeat (4) @(posedge clk);
    #1;
    check("burst_ready_before_last", 32'({req_ready, rsp_valid, rsp_last}), 32'b010);
    @(posedge clk); #1;
    check("burst_ready_with_last", 32'({req_ready, rsp_valid, rsp_last}), 32'b111);
    wait_drain();

    // Address wrap 0xFE -> 0x01
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) wr(wrap_exp[i], $urandom);
    addr_log.delete();
    send(1'b0, 8'hFE, 4'd3, 32'd0, 1'b0, a1);
    wait_drain();
    check("wrap_issue_count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("wrap_sram_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));

    // Back-to-back bursts with req_valid held
    for (int i = 0; i < 8; i++) wr(8'(8'h30 + i), $urandom);
    send(1'b0, 8'h30, 4'd3, 32'd0, 1'b1, a1);
    send(1'b0, 8'h34, 4'd3, 32'd0, 1'b0, a2);
    check("b2b_accept_gap", 32'(a2 - a1), 32'd6);
    check("b2b_issue_next", 32'({sram_cs, sram_we, sram_addr}), 32'({2'b10, 8'h34}));
    wait_drain();

    // Write stalled behind a 16-beat read
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), $urandom);
    send(1'b0, 8'h40, 4'd15, 32'd0, 1'b0, a1);
    send(1'b1, 8'h45, 4'd0, 32'hCAFEF00D, 1'b0, a2);
    check("stall_accept_gap", 32'(a2 - a1), 32'd18);
    send(1'b0, 8'h45, 4'd0, 32'd0, 1'b0, a1);
    wait_drain();

    // Reset while beat 5 of a 16-beat burst is on the response port
    for (int i = 0; i < 16; i++) wr(8'(8'h60 + i), $urandom);
    send(1'b0, 8'h60, 4'd15, 32'd0, 1'b0, a1);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("rst_mid_pins", 32'({sram_cs, rsp_valid, req_ready, busy}), 32'b0010);
    repeat (20) @(posedge clk);
    #1;
    send(1'b0, 8'h61, 4'd0, 32'd0, 1'b0, a1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
